// File: rtl/tdm_pkg.sv
// Shared types and constants for the 1:8 TDM receive path.
package tdm_pkg;
  localparam int NCH_DEF  = 8;
  localparam int SELW_DEF = 3;

  // Slots per frame: data slots only, or data plus one trailing even-parity slot.
  localparam int FRAME_LEN_DATA = NCH_DEF;
  localparam int FRAME_LEN_PAR  = NCH_DEF + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2
  } state_t;
endpackage

// File: rtl/tdm_slot_cnt.sv
// Modulo-N slot counter: sync clear, load-1 on frame start, advance on enable.
module tdm_slot_cnt #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         ld1,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  logic at_top;

  assign at_top = (cnt == W'(N - 1));
  // A load-1 means a new frame's slot 0 was taken, so it never counts as a wrap.
  assign wrap   = en & ~ld1 & at_top;

  always_ff @(posedge clk) begin
    if (clr)      cnt <= '0;
    else if (ld1) cnt <= W'(1);
    else if (en)  cnt <= at_top ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/tdm_demux8.sv
// 1:8 TDM demultiplexer: rebuilds one parallel word per serial frame.
// TDM_DEMUX8_PARITY_EN adds a trailing even-parity slot and the parity_err output.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int NCH  = NCH_DEF,
  parameter int SELW = SELW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din,
  input  logic            din_valid,
  input  logic            frame_start,
  output logic [NCH-1:0]  out,
  output logic            out_valid,
  output logic [SELW-1:0] slot,
  output logic            busy,
  output logic            frame_abort
`ifdef TDM_DEMUX8_PARITY_EN
  ,
  output logic            parity_err
`endif
);
  state_t         state, state_nxt;
  logic           start, abort, cnt_en, wrap, cmpl;
  logic [NCH-1:0] asm_q, asm_nxt;

  tdm_slot_cnt #(.N(NCH), .W(SELW)) u_cnt (
    .clk  (clk),
    .clr  (rst),
    .en   (cnt_en),
    .ld1  (start),
    .cnt  (slot),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RECV;
`ifdef TDM_DEMUX8_PARITY_EN
      RECV: if (wrap) state_nxt = PAR;
      PAR:  if (start) state_nxt = RECV;
            else if (din_valid) state_nxt = IDLE;
`else
      RECV: if (wrap) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // A frame_start outside IDLE drops the partial word and restarts at slot 0.
  always_comb begin
    start   = din_valid & frame_start;
    abort   = start & (state != IDLE);
    cnt_en  = din_valid & (state == RECV);
    asm_nxt = asm_q;
    if (start) begin
      asm_nxt    = '0;
      asm_nxt[0] = din;
    end else if (cnt_en) begin
      asm_nxt[slot] = din;
    end
`ifdef TDM_DEMUX8_PARITY_EN
    cmpl = (state == PAR) & din_valid & ~frame_start;
`else
    cmpl = wrap;
`endif
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q       <= '0;
      out         <= '0;
      out_valid   <= 1'b0;
      frame_abort <= 1'b0;
`ifdef TDM_DEMUX8_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      asm_q       <= asm_nxt;
      out_valid   <= cmpl;
      frame_abort <= abort;
`ifdef TDM_DEMUX8_PARITY_EN
      if (cmpl) begin
        out        <= asm_q;
        parity_err <= ^{asm_q, din};
      end
`else
      if (cmpl) out <= asm_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_tdm_demux8.sv
// Scoreboard bench for tdm_demux8; frames are pushed as expected words, a monitor pops on out_valid.
module tb_tdm_demux8;
`ifdef TDM_DEMUX8_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst, din, din_valid, frame_start;
  logic [7:0] out;
  logic       out_valid, busy, frame_abort;
  logic [2:0] slot;
`ifdef TDM_DEMUX8_PARITY_EN
  logic       parity_err;
`endif

  tdm_demux8 dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .out         (out),
    .out_valid   (out_valid),
    .slot        (slot),
    .busy        (busy),
    .frame_abort (frame_abort)
`ifdef TDM_DEMUX8_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vld_cyc[$];
  int   cyc = 0;
  int   abort_cnt = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every out_valid must match the oldest queued frame.
  always @(negedge clk) begin
    if (frame_abort === 1'b1) abort_cnt++;
    if (out_valid === 1'b1) begin
      vld_cyc.push_back(cyc);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid actual=%0h required=none", out);
      end else begin
        e = q.pop_front();
        chk("out", 32'(out), 32'(e.data));
`ifdef TDM_DEMUX8_PARITY_EN
        chk("parity_err", 32'(parity_err), 32'(e.perr));
`endif
      end
    end
  end

  task automatic bit_in(input logic fs, input logic d);
    @(negedge clk);
    din_valid = 1'b1; frame_start = fs; din = d;
  endtask

  task automatic gap();
    @(negedge clk);
    din_valid = 1'b0; frame_start = 1'b0; din = 1'b0;
  endtask

  task automatic frame_part(input logic [7:0] d, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) bit_in(i == 0, d[i]);
  endtask

  // Closes a frame: parity slot when enabled, then queues the expected word.
  task automatic frame_end(input logic [7:0] d, input logic bad);
`ifdef TDM_DEMUX8_PARITY_EN
    bit_in(1'b0, (^d) ^ bad);
    q.push_back({d, bad});
`else
    q.push_back({d, 1'b0});
`endif
  endtask

  task automatic frame(input logic [7:0] d, input logic bad);
    frame_part(d, 0, 7);
    frame_end(d, bad);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, a0;
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; frame_start = 1'b0;
    // 1: reset state
    @(negedge clk); @(negedge clk);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_slot", 32'(slot), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_abort", 32'(frame_abort), 32'h0);
    rst = 1'b0;

    // Data without frame_start in IDLE is discarded
    bit_in(1'b0, 1'b1); bit_in(1'b0, 1'b1); gap();
    chk("idle_slot", 32'(slot), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // 2: single frame D9
    frame(8'hD9, 1'b0); gap(); gap();
    chk("f2_busy", 32'(busy), 32'h0);
    chk("f2_slot", 32'(slot), 32'h0);

    // 3: stall after slot 3
    frame_part(8'hD9, 0, 3);
    for (int k = 0; k < 3; k++) begin
      gap();
      chk("stall_slot", 32'(slot), 32'h4);
      chk("stall_busy", 32'(busy), 32'h1);
    end
    frame_part(8'hD9, 4, 7);
    frame_end(8'hD9, 1'b0);
    gap(); gap();

    // 4: back-to-back D9, 3C
    n0 = vld_cyc.size();
    frame(8'hD9, 1'b0);
    frame(8'h3C, 1'b0);
    gap(); gap();
    chk("b2b_count", 32'(vld_cyc.size()), 32'(n0 + 2));
    if (vld_cyc.size() >= n0 + 2)
      chk("b2b_interval", 32'(vld_cyc[n0+1] - vld_cyc[n0]), 32'(FL));

    // 5: abort at slot 5, then A5
    a0 = abort_cnt;
    n0 = vld_cyc.size();
    frame_part(8'hFF, 0, 4);
    frame(8'hA5, 1'b0);
    gap(); gap();
    chk("abort_count", 32'(abort_cnt), 32'(a0 + 1));
    chk("abort_vld_count", 32'(vld_cyc.size()), 32'(n0 + 1));

    // 6: reset mid-frame; preceding word 00 so held and reset values agree
    frame(8'h00, 1'b0); gap(); gap();
    n0 = vld_cyc.size();
    frame_part(8'hFF, 0, 3);
    @(negedge clk);
    chk("pre_rst_slot", 32'(slot), 32'h4);
    rst = 1'b1; din_valid = 1'b1; frame_start = 1'b0; din = 1'b1;
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0; din = 1'b0;
    chk("mid_rst_out", 32'(out), 32'h0);
    chk("mid_rst_slot", 32'(slot), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    gap(); gap();
    chk("mid_rst_no_vld", 32'(vld_cyc.size()), 32'(n0));
    frame(8'h5A, 1'b0); gap(); gap();

`ifdef TDM_DEMUX8_PARITY_EN
    // 7/8: good and bad parity on D9
    frame(8'hD9, 1'b0); gap();
    frame(8'hD9, 1'b1); gap(); gap();
`endif

    gap(); gap(); gap();
    chk("scoreboard_empty", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
